// File: rtl/strobe_decoder3to8.sv
// strobe_decoder3to8
//   Sequential 3-to-8 decoder. A 3-bit code accepted over a valid/ready
//   handshake is driven as a one-hot strobe (8'b1000_0000 >> code) for DWELL
//   cycles, followed by GAP all-zero guard cycles, then done pulses for one
//   cycle as the block returns to IDLE.
//
// Parameters
//   DWELL  cycles each strobe is held (1..255)
//   GAP    all-zero guard cycles after each strobe (0..255)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   clear     synchronous abort back to IDLE (no done pulse)
//   in_valid  code present on in_code
//   in_code   3-bit code to decode
//   in_ready  registered, high only in IDLE
//   out       one-hot strobe, all zero when not strobing
//   busy      high in ACTIVE or GAP
//   done      one-cycle pulse on the first IDLE cycle after a full sequence
module strobe_decoder3to8 #(
  parameter int DWELL = 4,
  parameter int GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam logic [7:0] DWELL_C = 8'(DWELL);
  localparam logic [7:0] GAP_C   = 8'(GAP);

  generate
    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
      $error("strobe_decoder3to8: DWELL must be in 1..255");
    end
    if (GAP < 0 || GAP > 255) begin : g_bad_gap
      $error("strobe_decoder3to8: GAP must be in 0..255");
    end
  endgenerate

  // Same bit order as the 8-to-3 encoder: code 0 lights the MSB.
  function automatic logic [7:0] decode(input logic [2:0] code);
    decode = 8'b1000_0000 >> code;
  endfunction

  logic [1:0] state;
  logic [7:0] cnt;
  logic [2:0] code_q;

  // The counter is loaded on state entry and the state is left when it
  // reads 1, so it never decrements through zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      code_q   <= 3'd0;
      out      <= 8'h00;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      out      <= 8'h00;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (in_valid && in_ready) begin
            state    <= ST_ACTIVE;
            cnt      <= DWELL_C;
            code_q   <= in_code;
            out      <= decode(in_code);
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (cnt == 8'd1) begin
            out <= 8'h00;
            if (GAP_C != 8'd0) begin
              state <= ST_GAP;
              cnt   <= GAP_C;
            end else begin
              state    <= ST_IDLE;
              cnt      <= 8'd0;
              in_ready <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            cnt <= cnt - 8'd1;
            out <= decode(code_q);
          end
        end
        ST_GAP: begin
          if (cnt == 8'd1) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= 8'd0;
          out      <= 8'h00;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strobe_decoder3to8.sv
module tb_strobe_decoder3to8;

  logic       clk = 1'b0;
  logic       rst;
  // instance a: DWELL=4, GAP=2
  logic       a_clear, a_valid;
  logic [2:0] a_code;
  logic       a_ready, a_busy, a_done;
  logic [7:0] a_out;
  // instance b: DWELL=1, GAP=0
  logic       b_clear, b_valid;
  logic [2:0] b_code;
  logic       b_ready, b_busy, b_done;
  logic [7:0] b_out;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int a_done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) if (a_done) a_done_cnt <= a_done_cnt + 1;

  strobe_decoder3to8 #(.DWELL(4), .GAP(2)) dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_valid), .in_code(a_code),
    .in_ready(a_ready), .out(a_out), .busy(a_busy), .done(a_done));

  strobe_decoder3to8 #(.DWELL(1), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_valid), .in_code(b_code),
    .in_ready(b_ready), .out(b_out), .busy(b_busy), .done(b_done));

  typedef struct {
    logic [2:0] code;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference 8-to-3 encoder: bit 7 -> 0 ... bit 0 -> 7.
  function automatic logic [2:0] enc(input logic [7:0] o);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (o[i]) r = 3'(7 - i);
    return r;
  endfunction

  task automatic wait_a_ready(input string name);
    int n;
    n = 0;
    while (!a_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) chk({name, "_ready_timeout"}, 32'(a_ready), 32'd1);
  endtask

  int t_prev, t_acc;

  initial begin
    vecs[0] = '{3'd0, 8'h80}; vecs[1] = '{3'd1, 8'h40};
    vecs[2] = '{3'd2, 8'h20}; vecs[3] = '{3'd3, 8'h10};
    vecs[4] = '{3'd4, 8'h08}; vecs[5] = '{3'd5, 8'h04};
    vecs[6] = '{3'd6, 8'h02}; vecs[7] = '{3'd7, 8'h01};

    rst = 1'b1;
    a_clear = 0; a_valid = 0; a_code = 0;
    b_clear = 0; b_valid = 0; b_code = 0;
    #2;
    chk("rst_out", 32'(a_out), 32'h00);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(a_done), 32'd0);

    // ---- sweep 0..7, back to back ----
    a_done_cnt = 0;
    t_prev = -1;
    for (int i = 0; i < 8; i++) begin
      wait_a_ready("sweep");
      a_valid = 1'b1; a_code = vecs[i].code;
      @(posedge clk);
      t_acc = cycle;
      #1 a_valid = 1'b0; a_code = 3'(~vecs[i].code);
      if (t_prev >= 0) chk($sformatf("sweep_spacing%0d", i), 32'(t_acc - t_prev), 32'd7);
      t_prev = t_acc;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("sweep_out%0d_%0d", i, k), 32'(a_out), 32'(vecs[i].exp));
        chk($sformatf("sweep_enc%0d_%0d", i, k), 32'(enc(a_out)), 32'(vecs[i].code));
        chk($sformatf("sweep_busy%0d_%0d", i, k), 32'({a_busy, a_ready}), 32'b10);
      end
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk($sformatf("sweep_gap%0d_%0d", i, k), 32'({a_out, a_busy, a_ready, a_done}), 32'({8'h00, 3'b100}));
      end
      @(negedge clk);
      chk($sformatf("sweep_idle%0d", i), 32'({a_out, a_busy, a_ready, a_done}), 32'({8'h00, 3'b011}));
    end
    @(negedge clk);
    chk("sweep_done_drop", 32'(a_done), 32'd0);
    chk("sweep_done_cnt", 32'(a_done_cnt), 32'd8);

    // ---- DWELL=1, GAP=0, code 5 then immediate second accept ----
    b_valid = 1'b1; b_code = 3'd5;
    @(posedge clk); #1 b_valid = 1'b0;
    @(negedge clk);
    chk("b_strobe", 32'({b_out, b_busy, b_ready}), 32'({8'h04, 2'b10}));
    @(negedge clk);
    chk("b_idle", 32'({b_out, b_busy, b_ready, b_done}), 32'({8'h00, 3'b011}));
    b_valid = 1'b1; b_code = 3'd2;
    @(posedge clk); #1 b_valid = 1'b0;
    @(negedge clk);
    chk("b_second", 32'({b_out, b_done}), 32'({8'h20, 1'b0}));
    @(negedge clk);
    chk("b_second_done", 32'({b_out, b_done, b_ready}), 32'({8'h00, 2'b11}));

    // ---- ignore while busy ----
    @(negedge clk);
    a_valid = 1'b1; a_code = 3'd3;
    @(posedge clk); #1 a_code = 3'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("busy_out%0d", k), 32'(a_out), (k < 4) ? 32'h10 : 32'h00);
      chk($sformatf("busy_ready%0d", k), 32'(a_ready), 32'd0);
    end
    @(negedge clk);
    chk("busy_gap2", 32'({a_out, a_ready}), 32'({8'h00, 1'b0}));
    @(negedge clk);
    chk("busy_first_idle", 32'({a_ready, a_done}), 32'b11);
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    chk("busy_code6", 32'(a_out), 32'h02);
    wait_a_ready("busy");
    @(negedge clk);

    // ---- clear mid-ACTIVE ----
    a_valid = 1'b1; a_code = 3'd2;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    chk("clr_strobe1", 32'(a_out), 32'h20);
    @(negedge clk);
    chk("clr_strobe2", 32'(a_out), 32'h20);
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    chk("clr_after", 32'({a_out, a_busy, a_ready, a_done}), 32'({8'h00, 3'b010}));
    // handshake together with clear must not be accepted
    a_clear = 1'b1; a_valid = 1'b1; a_code = 3'd0;
    @(negedge clk);
    a_clear = 1'b0;
    chk("clr_hs_ignored", 32'({a_out, a_busy, a_done}), 32'({8'h00, 2'b00}));
    a_code = 3'd7;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    chk("clr_code7", 32'(a_out), 32'h01);
    wait_a_ready("clr");
    chk("clr_code7_done", 32'(a_done), 32'd1);
    @(negedge clk);

    // ---- async reset mid-GAP ----
    a_valid = 1'b1; a_code = 3'd4;
    @(posedge clk); #1 a_valid = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("rgap_in_gap", 32'({a_out, a_busy, a_ready}), 32'({8'h00, 2'b10}));
    #2 rst = 1'b1;
    #1;
    chk("rgap_async", 32'({a_out, a_busy, a_done, a_ready}), 32'({8'h00, 3'b001}));
    #1 rst = 1'b0;
    a_valid = 1'b1; a_code = 3'd1;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    chk("rgap_code1", 32'({a_out, a_busy}), 32'({8'h40, 1'b1}));
    wait_a_ready("rgap");
    chk("rgap_done", 32'(a_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
